mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 21 ++
 rtl/arb_timer.sv | 34 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam int BE_W             = 4;
  localparam int TIMEOUT_DEF      = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Wait counter for an outstanding memory grant, flags the abort cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts every grant cycle without m_ack.
// Ports: clk, rstd (sync, active-high), start (grant issued this cycle),
//        active (a grant is outstanding), m_ack, expired (abort now).
module arb_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstd,
  input  logic start,
  input  logic active,
  input  logic m_ack,
  output logic expired
);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rstd) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (active && !m_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // m_ack in the last allowed cycle wins over the abort.
  assign expired = active && !m_ack && (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory.
// Latency: req in cycle 0, m_req in cycle 1, ack no earlier than cycle 2.
// Backpressure: requesters hold req until ack; stall holds the core meanwhile.
// Ports: clk, rstd; fetch side i_req/i_addr -> i_ack/i_rdata; data side
//        d_req/d_we/d_be/d_addr/d_wdata -> d_ack/d_rdata; x_err flags a
//        timed-out ack; m_* is the registered memory request, m_ack/m_rdata
//        its completion; stall is the combinational pc hold.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rstd,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic            i_ack,
  output logic [31:0]     i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [31:0]     d_addr,
  input  logic [31:0]     d_wdata,
  output logic            d_ack,
  output logic [31:0]     d_rdata,
  output logic            x_err,
  output logic            m_req,
  output logic            m_we,
  output logic [BE_W-1:0] m_be,
  output logic [31:0]     m_addr,
  output logic [31:0]     m_wdata,
  input  logic            m_ack,
  input  logic [31:0]     m_rdata,
  output logic            stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] streak;
  logic       i_elig, d_elig, grant_d, grant_i, expired;

  // A requester whose ack is out this cycle is still holding req; skip it.
  assign i_elig  = i_req && !i_ack;
  assign d_elig  = d_req && !d_ack;
  assign grant_d = (state == IDLE) && d_elig && !((streak == LIMIT) && i_elig);
  assign grant_i = (state == IDLE) && i_elig && !grant_d;
  assign stall   = (i_req || d_req) && !(i_ack || d_ack);

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rstd    (rstd),
    .start   (grant_d || grant_i),
    .active  (state != IDLE),
    .m_ack   (m_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rstd) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      x_err   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      x_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= GRANT_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_be    <= d_be;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            // Only data grants that actually bypass a waiting fetch count.
            if (i_elig) streak <= sat_inc(streak, LIMIT);
          end else if (grant_i) begin
            state   <= GRANT_I;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            streak  <= '0;
          end
        end
        GRANT_I: begin
          if (m_ack || expired) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            i_ack   <= 1'b1;
            x_err   <= !m_ack;
            i_rdata <= m_ack ? m_rdata : 32'h0;
          end
        end
        GRANT_D: begin
          if (m_ack || expired) begin
            state <= IDLE;
            m_req <= 1'b0;
            d_ack <= 1'b1;
            x_err <= !m_ack;
            // Stores leave the last load data in place.
            if (!m_ack)     d_rdata <= 32'h0;
            else if (!m_we) d_rdata <= m_rdata;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import core_pkg::*;

  localparam int TO = 16;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        i_ack, d_ack, x_err, m_req, m_we, stall;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rstd(rstd),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .x_err(x_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
  );

  // ---------------- memory responder ----------------
  int  mem_lat = 0;
  bit  mem_on = 1'b1;
  bit  pulse_ack = 1'b0;
  int  lat_cnt = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a + 32'h1000_0000);
  endfunction

  always @(posedge clk) begin
    #3;
    if (m_req && mem_on && lat_cnt == mem_lat) begin
      m_ack   = 1'b1;
      m_rdata = memval(m_addr);
      lat_cnt = 0;
    end else begin
      m_ack   = pulse_ack;
      m_rdata = pulse_ack ? 32'h55 : 32'h0;
      lat_cnt = m_req ? lat_cnt + 1 : 0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum {NONE, FETCH, DATA} who_t;
  who_t        owner = NONE;
  int          held = 0;
  int          e_streak = 0;
  bit          mvalid = 1'b0;
  logic        e_iack = 1'b0, e_dack = 1'b0, e_err = 1'b0;
  logic [31:0] e_ird = 32'h0, e_drd = 32'h0;
  logic        e_mreq = 1'b0, e_mwe = 1'b0;
  logic [3:0]  e_mbe = 4'h0;
  logic [31:0] e_maddr = 32'h0, e_mwdata = 32'h0;
  bit          m_ia, m_da, m_ie, m_de, m_tmo;

  always @(posedge clk) begin
    m_ia = e_iack;
    m_da = e_dack;
    if (rstd) begin
      owner = NONE; held = 0; e_streak = 0; mvalid = 1'b1;
      e_iack = 0; e_dack = 0; e_err = 0; e_ird = 0; e_drd = 0;
      e_mreq = 0; e_mwe = 0; e_mbe = 0; e_maddr = 0; e_mwdata = 0;
    end else begin
      e_iack = 0; e_dack = 0; e_err = 0;
      if (owner == NONE) begin
        m_ie = i_req && !m_ia;
        m_de = d_req && !m_da;
        if (m_de && !(m_ie && e_streak == SL)) begin
          owner = DATA; e_mreq = 1; e_mwe = d_we; e_mbe = d_be;
          e_maddr = d_addr; e_mwdata = d_wdata;
          if (m_ie) e_streak = (e_streak < SL) ? e_streak + 1 : SL;
        end else if (m_ie) begin
          owner = FETCH; e_mreq = 1; e_mwe = 0; e_mbe = 0;
          e_maddr = i_addr; e_mwdata = 0; e_streak = 0;
        end
        held = 0;
      end else begin
        held++;
        m_tmo = !m_ack && (held == TO);
        if (m_ack || m_tmo) begin
          e_mreq = 0;
          e_err  = m_tmo;
          if (owner == FETCH) begin
            e_iack = 1;
            e_ird  = m_tmo ? 32'h0 : m_rdata;
          end else begin
            e_dack = 1;
            if (m_tmo) e_drd = 32'h0;
            else if (!e_mwe) e_drd = m_rdata;
          end
          owner = NONE;
        end
      end
    end
  end

  // ---------------- literal expectations recorded by the stimulus ----------------
  string       lit_nm  [0:127];
  logic [31:0] lit_act [0:127];
  logic [31:0] lit_exp [0:127];
  int          lit_n = 0;

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    lit_nm[lit_n]  = nm;
    lit_act[lit_n] = a;
    lit_exp[lit_n] = e;
    lit_n++;
  endtask

  // ---------------- single compare process ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int lit_done = 0;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    while (lit_done < lit_n) begin
      cmp(lit_nm[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      lit_done++;
    end
    if (mvalid) begin
      cmp("i_ack",   32'(i_ack),   32'(e_iack));
      cmp("d_ack",   32'(d_ack),   32'(e_dack));
      cmp("x_err",   32'(x_err),   32'(e_err));
      cmp("i_rdata", i_rdata,      e_ird);
      cmp("d_rdata", d_rdata,      e_drd);
      cmp("m_req",   32'(m_req),   32'(e_mreq));
      cmp("stall",   32'(stall),   32'((i_req || d_req) && !(e_iack || e_dack)));
      if (e_mreq) begin
        cmp("m_we",    32'(m_we),  32'(e_mwe));
        cmp("m_be",    32'(m_be),  32'(e_mbe));
        cmp("m_addr",  m_addr,     e_maddr);
        cmp("m_wdata", m_wdata,    e_mwdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt;
  bit got;
  int grants_d;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    tick(); tick(); #1;
    lit("rst m_req",   32'(m_req), 32'd0);
    lit("rst i_ack",   32'(i_ack), 32'd0);
    lit("rst d_ack",   32'(d_ack), 32'd0);
    lit("rst x_err",   32'(x_err), 32'd0);
    lit("rst m_addr",  m_addr,     32'd0);
    lit("rst i_rdata", i_rdata,    32'd0);
    lit("rst d_rdata", d_rdata,    32'd0);
    lit("rst state",   32'(dut.state), 32'(IDLE));
    rstd = 1'b0;

    // single fetch, memory answers in the first grant cycle
    tick(); i_req = 1; i_addr = 32'h100; #1;
    lit("fetch stall c0", 32'(stall), 32'd1);
    tick(); #1;
    lit("fetch m_req c1",  32'(m_req), 32'd1);
    lit("fetch m_addr c1", m_addr,     32'h100);
    lit("fetch m_we c1",   32'(m_we),  32'd0);
    lit("fetch stall c1",  32'(stall), 32'd1);
    tick(); #1;
    lit("fetch i_ack c2",   32'(i_ack), 32'd1);
    lit("fetch i_rdata c2", i_rdata,    32'h13);
    lit("fetch x_err c2",   32'(x_err), 32'd0);
    lit("fetch stall c2",   32'(stall), 32'd0);
    i_req = 0;

    // conflict: store wins, fetch follows in the data ack cycle
    tick();
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick(); #1;
    lit("conf m_we",    32'(m_we), 32'd1);
    lit("conf m_addr",  m_addr,    32'h2000);
    lit("conf m_wdata", m_wdata,   32'hDEADBEEF);
    lit("conf m_be",    32'(m_be), 32'hF);
    tick(); #1;
    lit("conf d_ack",     32'(d_ack), 32'd1);
    lit("conf i_ack low", 32'(i_ack), 32'd0);
    d_req = 0; d_we = 0; d_be = 4'h0;
    tick(); #1;
    lit("conf fetch m_req",  32'(m_req), 32'd1);
    lit("conf fetch m_addr", m_addr,     32'h300);
    lit("conf fetch m_we",   32'(m_we),  32'd0);
    tick(); #1;
    lit("conf i_ack",   32'(i_ack), 32'd1);
    lit("conf i_rdata", i_rdata,    32'h1000_0300);
    i_req = 0;

    // starvation: four data grants bypass a waiting fetch, the fifth round
    // goes to the fetch. The fetch side backs off in each data ack cycle so
    // the data side can win the next round.
    grants_d = 0;
    for (int r = 0; r < 4; r++) begin
      tick();
      i_req = 1; i_addr = 32'h400;
      d_req = 1; d_we = 0; d_addr = 32'h500 + 32'(r * 4);
      tick(); #1;
      if (m_req && !m_we && m_addr == 32'h500 + 32'(r * 4)) grants_d++;
      tick(); #1;
      lit("starve d_ack", 32'(d_ack), 32'd1);
      d_req = 0; i_req = 0;
    end
    lit("starve data grants", 32'(grants_d), 32'd4);
    tick();
    i_req = 1; d_req = 1; d_addr = 32'h520;
    tick(); #1;
    lit("starve fetch wins", m_addr, 32'h400);
    lit("starve fetch we",   32'(m_we), 32'd0);
    lit("starve streak 0",   32'(dut.streak), 32'd0);
    tick(); #1;
    lit("starve i_ack", 32'(i_ack), 32'd1);
    i_req = 0;
    tick(); #1;
    lit("post starve m_addr", m_addr, 32'h520);
    tick(); #1;
    lit("post starve d_ack",   32'(d_ack), 32'd1);
    lit("post starve d_rdata", d_rdata,    32'h1000_0520);
    d_req = 0;

    // timeout: load with no memory answer
    mem_on = 0;
    tick(); d_req = 1; d_we = 0; d_addr = 32'h600;
    cnt = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick(); #1;
      if (d_ack) got = 1;
      else if (m_req) cnt++;
    end
    lit("tmo ack seen",    32'(got),     32'd1);
    lit("tmo m_req cycles", 32'(cnt),    32'd16);
    lit("tmo x_err",       32'(x_err),   32'd1);
    lit("tmo d_rdata",     d_rdata,      32'd0);
    lit("tmo stall",       32'(stall),   32'd0);
    d_req = 0;

    // reset in the third GRANT_D cycle, late m_ack right after it
    tick(); d_req = 1; d_addr = 32'h700;
    tick();
    tick();
    tick(); rstd = 1;
    tick(); rstd = 0; pulse_ack = 1; d_req = 0; #1;
    lit("rst-mid m_req", 32'(m_req), 32'd0);
    lit("rst-mid d_ack", 32'(d_ack), 32'd0);
    tick(); pulse_ack = 0; #1;
    lit("rst-mid d_ack late", 32'(d_ack), 32'd0);
    lit("rst-mid m_req late", 32'(m_req), 32'd0);
    lit("rst-mid state",      32'(dut.state), 32'(IDLE));

    // arbitration resumes: fetch with two cycles of memory latency
    mem_on = 1; mem_lat = 2;
    tick(); i_req = 1; i_addr = 32'h800;
    cnt = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(); #1;
      if (i_ack) got = 1;
      else if (m_req) cnt++;
    end
    lit("lat2 ack seen", 32'(got), 32'd1);
    lit("lat2 m_req cycles", 32'(cnt), 32'd3);
    lit("lat2 i_rdata", i_rdata, 32'h1000_0800);
    lit("lat2 x_err",   32'(x_err), 32'd0);
    i_req = 0;

    tick(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
